aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_pkg.sv | 50 +++++
 rtl/aes_key_step.sv | 21 ++
 rtl/aes_round_ctrl.sv | 91 +++++++++
 tb/tb_aes_round_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 types, constants and GF(2^8) helper functions
package aes_pkg;
  localparam int NUM_ROUNDS = 10;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} aes_state_e;
  // Indexed directly by the round counter; entries 0 and 11..15 are never used in RUN
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 followed by the FIPS-197 affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one AES-128 key-schedule step (round key i -> round key i+1)
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_next_key
);
  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_tmp, w_n0, w_n1, w_n2, w_n3;

  // RotWord, SubWord and rcon on the last word, then chain the XORs across the key
  always_comb begin
    {w_w0, w_w1, w_w2, w_w3} = i_key;
    w_tmp = {sbox(w_w3[23:16]) ^ i_rcon, sbox(w_w3[15:8]), sbox(w_w3[7:0]), sbox(w_w3[31:24])};
    w_n0 = w_w0 ^ w_tmp;
    w_n1 = w_w1 ^ w_n0;
    w_n2 = w_w2 ^ w_n1;
    w_n3 = w_w3 ^ w_n2;
    o_next_key = {w_n0, w_n1, w_n2, w_n3};
  end
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 encryptor, one round per cycle; AES_ROUND_CTRL_FLUSH_EN adds flush_i
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  input  logic [127:0] key_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
`ifdef AES_ROUND_CTRL_FLUSH_EN
  input  logic         flush_i,
`endif
  output logic [127:0] data_o,
  output logic [3:0]   round_o
);
  aes_state_e   r_fsm, w_fsm_n;
  logic [127:0] r_state, r_key, w_state_n, w_key_n, w_rk, w_sr, w_mc, w_round;
  logic [3:0]   r_rnd, w_rnd_n;

  aes_key_step u_key_step (
    .i_key      (r_key),
    .i_rcon     (RCON[r_rnd]),
    .o_next_key (w_rk)
  );

  // One cipher round: SubBytes+ShiftRows, MixColumns skipped on the last round, AddRoundKey
  always_comb begin
    w_sr = '0;
    w_mc = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[127-8*(4*c+r) -: 8] = sbox(r_state[127-8*(4*((c+r)%4)+r) -: 8]);
    for (int c = 0; c < 4; c++)
      w_mc[127-32*c -: 32] = mix_column(w_sr[127-32*c -: 32]);
    w_round = ((r_rnd == 4'(NUM_ROUNDS)) ? w_sr : w_mc) ^ w_rk;
  end

  // Next-state and datapath update; flush overrides everything outside IDLE
  always_comb begin
    w_fsm_n   = r_fsm;
    w_state_n = r_state;
    w_key_n   = r_key;
    w_rnd_n   = r_rnd;
    case (r_fsm)
      ST_IDLE: if (in_valid_i) begin
        w_fsm_n   = ST_RUN;
        w_state_n = data_i ^ key_i;
        w_key_n   = key_i;
        w_rnd_n   = 4'd1;
      end
      ST_RUN: begin
        w_state_n = w_round;
        w_key_n   = w_rk;
        w_rnd_n   = r_rnd + 4'd1;
        w_fsm_n   = (r_rnd == 4'(NUM_ROUNDS)) ? ST_DONE : ST_RUN;
      end
      ST_DONE: w_fsm_n = out_ready_i ? ST_IDLE : ST_DONE;
      default: w_fsm_n = ST_IDLE;
    endcase
`ifdef AES_ROUND_CTRL_FLUSH_EN
    if (flush_i && r_fsm != ST_IDLE) begin
      w_fsm_n   = ST_IDLE;
      w_state_n = '0;
      w_key_n   = '0;
      w_rnd_n   = '0;
    end
`endif
  end

  // State, key and round registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_key   <= '0;
      r_rnd   <= '0;
    end else begin
      r_fsm   <= w_fsm_n;
      r_state <= w_state_n;
      r_key   <= w_key_n;
      r_rnd   <= w_rnd_n;
    end

  assign in_ready_o  = (r_fsm == ST_IDLE);
  assign out_valid_o = (r_fsm == ST_DONE);
  assign data_o      = r_state;
  assign round_o     = (r_fsm == ST_RUN) ? r_rnd : (r_fsm == ST_DONE) ? 4'(NUM_ROUNDS) : 4'd0;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for aes_round_ctrl using published AES-128 vectors
module tb_aes_round_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] data_in = '0;
  logic [127:0] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;
  logic [3:0]   round;
`ifdef AES_ROUND_CTRL_FLUSH_EN
  logic         flush = 1'b0;
`endif
  logic [127:0] sb [$];
  int tests = 0;
  int fails = 0;

  aes_round_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_i      (data_in),
    .key_i       (key_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef AES_ROUND_CTRL_FLUSH_EN
    .flush_i     (flush),
`endif
    .data_o      (data_out),
    .round_o     (round)
  );

  always #5 clk = ~clk;

  task automatic accept(input logic [127:0] d, input logic [127:0] k, input logic [127:0] e);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL accept_ready got %b want 1", in_ready); end
    in_valid = 1'b1;
    data_in  = d;
    key_in   = k;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 30) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, out_valid, round} !== {1'b1, 1'b0, 4'd0}) begin
      fails++; $display("FAIL reset_ctrl got rdy=%b vld=%b rnd=%0d want 1 0 0", in_ready, out_valid, round);
    end
    tests++;
    if (data_out !== 128'h0) begin fails++; $display("FAIL reset_data got %h want 0", data_out); end
  endtask

  task automatic test_fips_c1();
    int cnt;
    logic [127:0] e;
    accept(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_out(cnt);
    e = sb.pop_front();
    tests++;
    if (cnt !== 10) begin fails++; $display("FAIL c1_latency got %0d want 10", cnt); end
    tests++;
    if (data_out !== e) begin fails++; $display("FAIL c1_data got %h want %h", data_out, e); end
    release_out();
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++; $display("FAIL c1_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_rounds();
    logic [127:0] e;
    accept(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
           128'h3925841d02dc09fbdc118597196a0b32);
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (round !== 4'(k + 1) || out_valid !== 1'b0 || in_ready !== 1'b0) begin
        fails++; $display("FAIL rounds_step%0d got rnd=%0d vld=%b rdy=%b want %0d 0 0", k, round, out_valid, in_ready, k + 1);
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    tests++;
    if (out_valid !== 1'b1 || round !== 4'd10 || data_out !== e) begin
      fails++; $display("FAIL rounds_done got vld=%b rnd=%0d data=%h want 1 10 %h", out_valid, round, data_out, e);
    end
    release_out();
    tests++;
    if (round !== 4'd0) begin fails++; $display("FAIL rounds_idle got %0d want 0", round); end
  endtask

  task automatic test_backpressure();
    int cnt;
    logic [127:0] e;
    accept(128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    wait_out(cnt);
    e = sb.pop_front();
    in_valid = 1'b1;
    data_in  = 128'hdeadbeef;
    key_in   = 128'hcafef00d;
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== e || round !== 4'd10) begin
        fails++; $display("FAIL hold%0d got vld=%b rdy=%b rnd=%0d data=%h want 1 0 10 %h", k, out_valid, in_ready, round, data_out, e);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    release_out();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL hold_release got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0 || round !== 4'd0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL hold_ignored got vld=%b rnd=%0d rdy=%b want 0 0 1", out_valid, round, in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    int cnt;
    logic [127:0] e;
    accept(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    repeat (4) @(negedge clk);
    tests++;
    if (round !== 4'd5) begin fails++; $display("FAIL rst_round got %0d want 5", round); end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, round} !== {1'b1, 1'b0, 4'd0} || data_out !== 128'h0) begin
      fails++; $display("FAIL rst_async got rdy=%b vld=%b rnd=%0d data=%h want 1 0 0 0", in_ready, out_valid, round, data_out);
    end
    e = sb.pop_front();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_no_output got %b want 0", out_valid); end
    accept(128'h6bc1bee22e409f96e93d7e117393172a, 128'h2b7e151628aed2a6abf7158809cf4f3c,
           128'h3ad77bb40d7a3660a89ecaf32466ef97);
    wait_out(cnt);
    e = sb.pop_front();
    tests++;
    if (cnt !== 10 || data_out !== e) begin
      fails++; $display("FAIL rst_next got lat=%0d data=%h want 10 %h", cnt, data_out, e);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [127:0] e;
    logic [127:0] pt [3] = '{128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h3243f6a8885a308d313198a2e0370734,
                             128'h00112233445566778899aabbccddeeff};
    logic [127:0] ky [3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                             128'h000102030405060708090a0b0c0d0e0f};
    logic [127:0] ct [3] = '{128'hf5d3d58503b9699de785895a96fdbaaf, 128'h3925841d02dc09fbdc118597196a0b32,
                             128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    for (int v = 0; v < 3; v++) begin
      accept(pt[v], ky[v], ct[v]);
      wait_out(cnt);
      e = sb.pop_front();
      tests++;
      if (cnt !== 10 || data_out !== e) begin
        fails++; $display("FAIL b2b%0d got lat=%0d data=%h want 10 %h", v, cnt, data_out, e);
      end
      release_out();
    end
  endtask

`ifdef AES_ROUND_CTRL_FLUSH_EN
  task automatic test_flush();
    int cnt;
    logic [127:0] e;
    accept(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
           128'h3925841d02dc09fbdc118597196a0b32);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    e = sb.pop_front();
    tests++;
    if ({in_ready, out_valid, round} !== {1'b1, 1'b0, 4'd0} || data_out !== 128'h0) begin
      fails++; $display("FAIL flush_idle got rdy=%b vld=%b rnd=%0d data=%h want 1 0 0 0", in_ready, out_valid, round, data_out);
    end
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid === 1'b1) cnt++;
    end
    tests++;
    if (cnt !== 0) begin fails++; $display("FAIL flush_no_output got %0d pulses want 0", cnt); end
    accept(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
           128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_out(cnt);
    e = sb.pop_front();
    tests++;
    if (cnt !== 10 || data_out !== e) begin
      fails++; $display("FAIL flush_next got lat=%0d data=%h want 10 %h", cnt, data_out, e);
    end
    flush = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || data_out !== 128'h0) begin
      fails++; $display("FAIL flush_done got vld=%b data=%h want 0 0", out_valid, data_out);
    end
  endtask
`endif

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_fips_c1();
    test_rounds();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
`ifdef AES_ROUND_CTRL_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
